multdiv_sequencer: RTL and testbench

- Iterative signed multiply/divide engine plus its controller, for the execute stage of the 5-stage pipeline.
- Accepts one mult/div request per handshake and runs a one-bit-per-cycle shift-add or restoring-divide datapath for WIDTH cycles.
- Returns the result with its destination tag and an exception flag.
- Drives the pipeline stall line so decode and execute hold while an operation is in flight.

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_step.sv | 39 +++
 rtl/multdiv_sequencer.sv | 130 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide sequencer.
package multdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Pipeline ALU opcodes from which decode derives req_op.
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the unsigned shift-add multiply or restoring divide.
// Mult: acc is the product, opa the multiplicand, opb the multiplier (shifted out LSB first).
// Div:  acc upper half is the remainder, opa the dividend that becomes the quotient, opb the divisor.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0]   opa_nxt,
  output logic [WIDTH-1:0]   opb_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Next-iteration datapath; the mult carry-out is kept so the right shift never loses it.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (op == OP_MULT) begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
      opb_nxt = opb >> 1;
    end else begin
      opa_nxt = {opa[WIDTH-2:0], ~diff[WIDTH]};
      acc_nxt = {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-1:0]};
    end
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Signed multiply/divide sequencer for the execute stage; one bit per cycle.
//
// state  | meaning
// IDLE   | ready for a request; stall raised combinationally if one is present
// RUN    | WIDTH iterations of the step datapath
// DONE   | one-cycle result_valid pulse, then back to IDLE
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_exc,
  output logic [TAG_W-1:0] result_tag
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [2*WIDTH-1:0] LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nxt;
  logic               op_q, sign_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WIDTH-1:0]   opa_q, opb_q, opa_nxt, opb_nxt;
  logic [2*WIDTH-1:0] acc_q, acc_nxt, mag;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   abs_a, abs_b, res_fin;
  logic               accept, a_zero, b_zero, last, exc;

  assign req_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign stall        = busy | (req_valid & (state == S_IDLE));
  assign result_valid = (state == S_DONE);

  assign accept = req_valid & req_ready & ~flush;
  assign a_zero = (req_a == '0);
  assign b_zero = (req_b == '0);
  assign abs_a  = req_a[WIDTH-1] ? -req_a : req_a;
  assign abs_b  = req_b[WIDTH-1] ? -req_b : req_b;
  assign last   = (state == S_RUN) && (cnt_q == CNT_W'(WIDTH-1));

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .opa     (opa_q),
    .opb     (opb_q),
    .acc_nxt (acc_nxt),
    .opa_nxt (opa_nxt),
    .opb_nxt (opb_nxt)
  );

  // Final magnitude from the last iteration; signed overflow allows one extra unit when negative.
  always_comb begin
    mag     = (op_q == OP_MULT) ? acc_nxt : {{WIDTH{1'b0}}, opa_nxt};
    res_fin = sign_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
    exc     = sign_q ? (mag > LIMIT) : (mag >= LIMIT);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush aborts RUN, while DONE always completes its pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (req_op == OP_DIV && b_zero) ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration registers and committed result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= OP_MULT;
      sign_q     <= 1'b0;
      tag_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result     <= '0;
      result_exc <= 1'b0;
      result_tag <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      tag_q  <= req_tag;
      opa_q  <= abs_a;
      opb_q  <= abs_b;
      sign_q <= (req_a[WIDTH-1] ^ req_b[WIDTH-1]) & ~a_zero & ~b_zero;
      acc_q  <= '0;
      cnt_q  <= '0;
      if (req_op == OP_DIV && b_zero) begin
        result     <= '0;
        result_exc <= 1'b1;
        result_tag <= req_tag;
      end
    end else if (state == S_RUN) begin
      acc_q <= acc_nxt;
      opa_q <= opa_nxt;
      opb_q <= opb_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (last && !flush) begin
        result     <= res_fin;
        result_exc <= exc;
        result_tag <= tag_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer.
module tb_multdiv_sequencer;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_op;
  logic [W-1:0]  req_a, req_b;
  logic [TW-1:0] req_tag;
  logic          flush, busy, stall, result_valid, result_exc;
  logic [W-1:0]  result;
  logic [TW-1:0] result_tag;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  multdiv_sequencer #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_tag      (req_tag),
    .flush        (flush),
    .busy         (busy),
    .stall        (stall),
    .result_valid (result_valid),
    .result       (result),
    .result_exc   (result_exc),
    .result_tag   (result_tag)
  );

  // Issue one request and wait (bounded) for its result; lat = cycles after the acceptance edge.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, output int lat, output logic [W-1:0] res,
                        output logic exc, output logic [TW-1:0] rtag, output logic hold_ok);
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge clock); #1;
    req_valid = 1'b0; req_op = ~op; req_a = $urandom; req_b = $urandom; req_tag = TW'($urandom);
    lat = -1; res = '0; exc = 1'b0; rtag = '0; hold_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (!busy || !stall) hold_ok = 1'b0;
      if (result_valid) begin
        lat = n; res = result; exc = result_exc; rtag = result_tag;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_tag = '0; flush = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (result_exc !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b expected 0", result_exc); end
    checks++; if (result_tag !== 5'd0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", result_tag); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b expected 0", stall); end
    req_valid = 1'b1; flush = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL idle_req_stall: got %b expected 1", stall); end
    req_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_mult();
    int lat; logic [W-1:0] res; logic exc; logic [TW-1:0] rtag; logic hold;
    run_op(1'b0, 32'd7, 32'hFFFFFFFD, 5'd9, lat, res, exc, rtag, hold);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", lat); end
    checks++; if (res !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_result: got %h expected ffffffeb", res); end
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL mult_exc: got %b expected 0", exc); end
    checks++; if (rtag !== 5'd9) begin errors++; $display("FAIL mult_tag: got %0d expected 9", rtag); end
    checks++; if (hold !== 1'b1) begin errors++; $display("FAIL mult_busy_stall: got %b expected 1", hold); end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mult_idle_after: busy=%b ready=%b expected 0/1", busy, req_ready); end
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, lat, res, exc, rtag, hold);
    checks++; if (res !== 32'd1 || exc !== 1'b0) begin errors++; $display("FAIL mult_neg_neg: got %h/%b expected 00000001/0", res, exc); end
    run_op(1'b0, 32'd0, 32'hFFFFFFFB, 5'd2, lat, res, exc, rtag, hold);
    checks++; if (res !== 32'd0 || exc !== 1'b0) begin errors++; $display("FAIL mult_zero: got %h/%b expected 00000000/0", res, exc); end
  endtask

  task automatic test_mult_overflow();
    int lat; logic [W-1:0] res; logic exc; logic [TW-1:0] rtag; logic hold;
    run_op(1'b0, 32'h00010000, 32'h00010000, 5'd3, lat, res, exc, rtag, hold);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL ovf_result: got %h expected 00000000", res); end
    checks++; if (exc !== 1'b1) begin errors++; $display("FAIL ovf_exc: got %b expected 1", exc); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_latency: got %0d expected 33", lat); end
    run_op(1'b0, 32'hFFFF0000, 32'h00008000, 5'd4, lat, res, exc, rtag, hold);
    checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL minint_prod_result: got %h expected 80000000", res); end
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL minint_prod_exc: got %b expected 0", exc); end
  endtask

  task automatic test_div();
    int lat; logic [W-1:0] res; logic exc; logic [TW-1:0] rtag; logic hold;
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, 5'd5, lat, res, exc, rtag, hold);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", lat); end
    checks++; if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_result: got %h expected fffffffd", res); end
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL div_exc: got %b expected 0", exc); end
    run_op(1'b1, 32'd5, 32'd0, 5'd6, lat, res, exc, rtag, hold);
    checks++; if (lat !== 1) begin errors++; $display("FAIL divzero_latency: got %0d expected 1", lat); end
    checks++; if (res !== 32'h0 || exc !== 1'b1) begin errors++; $display("FAIL divzero_result: got %h/%b expected 00000000/1", res, exc); end
    checks++; if (rtag !== 5'd6) begin errors++; $display("FAIL divzero_tag: got %0d expected 6", rtag); end
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd7, lat, res, exc, rtag, hold);
    checks++; if (res !== 32'h80000000 || exc !== 1'b1) begin errors++; $display("FAIL div_minint: got %h/%b expected 80000000/1", res, exc); end
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, 5'd8, lat, res, exc, rtag, hold);
    checks++; if (res !== 32'hFFFFFFF2 || exc !== 1'b0) begin errors++; $display("FAIL div_trunc: got %h/%b expected fffffff2/0", res, exc); end
  endtask

  task automatic test_flush_run();
    int lat; logic [W-1:0] res; logic exc; logic [TW-1:0] rtag; logic hold; logic seen;
    run_op(1'b0, 32'd2, 32'd3, 5'd4, lat, res, exc, rtag, hold);
    checks++; if (res !== 32'd6 || rtag !== 5'd4) begin errors++; $display("FAIL flush_pre: got %h tag %0d expected 00000006 tag 4", res, rtag); end
    @(negedge clock);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd5; req_b = 32'd5; req_tag = 5'd7;
    @(posedge clock); #1 req_valid = 1'b0;
    seen = 1'b0;
    repeat (9) begin @(negedge clock); if (result_valid) seen = 1'b1; end
    @(negedge clock); flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle: ready=%b busy=%b expected 1/0", req_ready, busy); end
    repeat (40) begin @(negedge clock); if (result_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b expected 0", seen); end
    checks++; if (result !== 32'd6 || result_tag !== 5'd4 || result_exc !== 1'b0) begin
      errors++; $display("FAIL flush_held: got %h/%0d/%b expected 00000006/4/0", result, result_tag, result_exc); end
    run_op(1'b0, 32'd6, 32'd7, 5'd8, lat, res, exc, rtag, hold);
    checks++; if (lat !== 33 || res !== 32'd42) begin errors++; $display("FAIL after_flush: got lat %0d res %h expected 33 0000002a", lat, res); end
  endtask

  task automatic test_flush_with_req();
    @(negedge clock);
    req_valid = 1'b1; flush = 1'b1; req_op = 1'b0; req_a = 32'd3; req_b = 32'd3; req_tag = 5'd1;
    @(posedge clock); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_req_busy: got %b expected 0", busy); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    @(negedge clock);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd5; req_b = 32'd5; req_tag = 5'd3;
    @(posedge clock); #1 req_valid = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy_pre: got %b expected 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL midrun_reset: busy=%b valid=%b expected 0/0", busy, result_valid); end
    checks++; if (result !== 32'h0 || result_tag !== 5'd0) begin errors++; $display("FAIL midrun_result: got %h/%0d expected 00000000/0", result, result_tag); end
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clock); if (result_valid || busy) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrun_no_valid: got %b expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, acc2; logic [W-1:0] r1, r2; logic [TW-1:0] g1, g2; logic stall_low, acc_seen, done1;
    t1 = -1; t2 = -1; acc2 = -1; r1 = '0; r2 = '0; g1 = '0; g2 = '0;
    stall_low = 1'b0; acc_seen = 1'b0; done1 = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd9; req_b = 32'd11; req_tag = 5'd1;
    @(posedge clock); #1;
    req_op = 1'b1; req_a = 32'hFFFFFF9C; req_b = 32'd3; req_tag = 5'd2;
    for (int n = 1; n <= 90; n++) begin
      if (acc_seen && req_valid) begin @(posedge clock); #1 req_valid = 1'b0; end
      @(negedge clock);
      if (stall !== 1'b1) stall_low = 1'b1;
      if (req_ready && req_valid && !acc_seen) begin acc2 = n; acc_seen = 1'b1; end
      if (result_valid) begin
        if (!done1) begin t1 = n; r1 = result; g1 = result_tag; done1 = 1'b1; end
        else begin t2 = n; r2 = result; g2 = result_tag; break; end
      end
    end
    req_valid = 1'b0;
    checks++; if (t1 !== 33 || r1 !== 32'd99 || g1 !== 5'd1) begin errors++; $display("FAIL b2b_first: got cyc %0d %h tag %0d expected 33 00000063 tag 1", t1, r1, g1); end
    checks++; if (acc2 !== 34) begin errors++; $display("FAIL b2b_accept: got %0d expected 34", acc2); end
    checks++; if (t2 !== 67) begin errors++; $display("FAIL b2b_second_cycle: got %0d expected 67", t2); end
    checks++; if (r2 !== 32'hFFFFFFDF || g2 !== 5'd2) begin errors++; $display("FAIL b2b_second: got %h tag %0d expected ffffffdf tag 2", r2, g2); end
    checks++; if (stall_low !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", stall_low); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mult_overflow();
    test_div();
    test_flush_run();
    test_flush_with_req();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
